// File: rtl/quad_home_ctrl.sv
// Homing controller for a quadrature axis: arms on start, waits for a fresh
// encoder index edge, captures the live count there and strobes a counter clear.
module quad_home_ctrl #(
    parameter int unsigned TIMEOUT = 50000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic        index,
    input  logic [31:0] count,
    output logic        cnt_clear,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [31:0] home_offset,
    output logic [7:0]  home_total
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        SEEK  = 2'd2,
        CLEAR = 2'd3
    } state_t;

    localparam logic [31:0] TIMER_LAST = 32'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic        s1_q, s2_q, s3_q;
    logic [31:0] timer_q, timer_d;
    logic        done_q, done_d;
    logic        error_q, error_d;
    logic [31:0] offset_q, offset_d;
    logic [7:0]  total_q, total_d;

    logic idx_rise;
    logic timeout_hit;

    assign idx_rise    = s2_q & ~s3_q;
    assign timeout_hit = (timer_q == TIMER_LAST);

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        done_d   = done_q;
        error_d  = error_q;
        offset_d = offset_q;
        total_d  = total_q;
        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    state_d = ARM;
                    done_d  = 1'b0;
                    error_d = 1'b0;
                    timer_d = '0;
                end
            end
            ARM: begin
                timer_d = timer_q + 32'd1;
                // Timeout beats advancing so the timer can never step past its limit.
                if (abort) begin
                    state_d = IDLE;
                end else if (timeout_hit) begin
                    state_d = IDLE;
                    error_d = 1'b1;
                end else if (!s2_q) begin
                    state_d = SEEK;
                end
            end
            SEEK: begin
                timer_d = timer_q + 32'd1;
                if (abort) begin
                    state_d = IDLE;
                end else if (idx_rise) begin
                    state_d  = CLEAR;
                    offset_d = count;
                end else if (timeout_hit) begin
                    state_d = IDLE;
                    error_d = 1'b1;
                end
            end
            CLEAR: begin
                state_d = IDLE;
                done_d  = 1'b1;
                if (total_q != 8'hFF) begin
                    total_d = total_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            s3_q     <= 1'b0;
            timer_q  <= '0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
            offset_q <= '0;
            total_q  <= '0;
        end else begin
            state_q  <= state_d;
            s1_q     <= index;
            s2_q     <= s1_q;
            s3_q     <= s2_q;
            timer_q  <= timer_d;
            done_q   <= done_d;
            error_q  <= error_d;
            offset_q <= offset_d;
            total_q  <= total_d;
        end
    end

    assign cnt_clear   = (state_q == CLEAR);
    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign error       = error_q;
    assign home_offset = offset_q;
    assign home_total  = total_q;

endmodule

// File: tb/tb_quad_home_ctrl.sv
// Bench for quad_home_ctrl: directed homing scenarios plus random traffic,
// all outputs compared every cycle against a behavioural model of the homing rules.
module tb_quad_home_ctrl;

    localparam int TO = 100;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        index = 1'b0;
    logic [31:0] count = '0;
    logic        cnt_clear, busy, done, error;
    logic [31:0] home_offset;
    logic [7:0]  home_total;

    always #5 clk = ~clk;

    quad_home_ctrl #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .index(index),
        .count(count), .cnt_clear(cnt_clear), .busy(busy), .done(done),
        .error(error), .home_offset(home_offset), .home_total(home_total)
    );

    int total = 0;
    int bad = 0;
    int clr_pulses = 0;
    bit model_valid = 0;

    // Model: a homing is "in progress" (busy), has "seen index low" once armed,
    // or is in its single clear cycle; index is seen through a 2-edge delay.
    bit          m_busy, m_seen_low, m_clear, m_done, m_err;
    logic [31:0] m_off;
    int          m_total;
    int          m_elapsed;
    bit          idx_ago1, idx_ago2, idx_ago3;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 40) $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit rise;
        if (!reset) begin
            m_busy = 0; m_seen_low = 0; m_clear = 0; m_done = 0; m_err = 0;
            m_off = '0; m_total = 0; m_elapsed = 0;
            idx_ago1 = 0; idx_ago2 = 0; idx_ago3 = 0;
            model_valid = 1;
            return;
        end
        rise = idx_ago2 && !idx_ago3;
        if (m_clear) begin
            m_clear = 0; m_busy = 0; m_done = 1;
            if (m_total < 255) m_total++;
        end else if (m_busy) begin
            if (abort) begin
                m_busy = 0;
            end else if (m_seen_low && rise) begin
                m_clear = 1; m_off = count;
            end else if (m_elapsed == TO - 1) begin
                m_busy = 0; m_err = 1;
            end else if (!m_seen_low && !idx_ago2) begin
                m_seen_low = 1;
            end
            m_elapsed++;
        end else if (start && !abort) begin
            m_busy = 1; m_seen_low = 0; m_done = 0; m_err = 0; m_elapsed = 0;
        end
        idx_ago3 = idx_ago2;
        idx_ago2 = idx_ago1;
        idx_ago1 = index;
    endtask

    always @(posedge clk) begin
        model_step();
        #1;
        if (model_valid) begin
            check("cnt_clear", 32'(cnt_clear), 32'(m_clear));
            check("busy", 32'(busy), 32'(m_busy));
            check("done", 32'(done), 32'(m_done));
            check("error", 32'(error), 32'(m_err));
            check("home_offset", home_offset, m_off);
            check("home_total", 32'(home_total), 32'(m_total));
            if (cnt_clear) clr_pulses++;
        end
    end

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        bit ok;
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1;
                break;
            end
        end
        check("wait_idle_in_budget", 32'(ok), 32'd1);
    endtask

    task automatic home_quick(input int i);
        index = 1'b0;
        repeat (3) @(negedge clk);
        pulse_start();
        @(negedge clk);
        count = $urandom;
        index = 1'b1;
        if (i % 2 == 1) pulse_start();
        wait_idle(20);
        index = 1'b0;
    endtask

    initial begin
        int lat;
        int p0;

        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_offset", home_offset, 32'd0);
        check("rst_total", 32'(home_total), 32'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Normal homing with latency measurement.
        pulse_start();
        repeat (10) @(negedge clk);
        count = 32'h0000_1234;
        index = 1'b1;
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #2;
            if (cnt_clear) begin
                lat = k;
                break;
            end
        end
        check("clear_latency_edges", 32'(lat), 32'd3);
        @(negedge clk);
        @(negedge clk);
        check("norm_offset", home_offset, 32'h0000_1234);
        check("norm_model_offset", m_off, 32'h0000_1234);
        check("norm_done", 32'(done), 32'd1);
        check("norm_error", 32'(error), 32'd0);
        check("norm_total", 32'(home_total), 32'd1);
        check("norm_clear_pulses", 32'(clr_pulses), 32'd1);
        index = 1'b0;
        repeat (3) @(negedge clk);

        // Timeout: index held low, error exactly TO cycles after ARM entry.
        p0 = clr_pulses;
        @(negedge clk) start = 1'b1;
        lat = 0;
        for (int k = 1; k <= 150; k++) begin
            @(posedge clk); #2;
            start = 1'b0;
            if (error) begin
                lat = k;
                break;
            end
        end
        check("timeout_edges", 32'(lat), 32'(TO + 1));
        check("timeout_busy", 32'(busy), 32'd0);
        check("timeout_done", 32'(done), 32'd0);
        check("timeout_no_clear", 32'(clr_pulses), 32'(p0));
        @(negedge clk);

        // Index already high at start: only the second rise is captured.
        index = 1'b1;
        repeat (3) @(negedge clk);
        pulse_start();
        count = 32'h5555_5555;
        repeat (20) @(negedge clk);
        check("prehigh_busy", 32'(busy), 32'd1);
        check("prehigh_offset", home_offset, 32'h0000_1234);
        check("prehigh_no_clear", 32'(clr_pulses), 32'(p0));
        index = 1'b0;
        repeat (3) @(negedge clk);
        count = 32'h0000_ABCD;
        index = 1'b1;
        wait_idle(20);
        check("prehigh_capture", home_offset, 32'h0000_ABCD);
        check("prehigh_total", 32'(home_total), 32'd2);
        index = 1'b0;
        repeat (3) @(negedge clk);

        // Abort in the same cycle as idx_rise.
        p0 = clr_pulses;
        pulse_start();
        repeat (2) @(negedge clk);
        count = 32'h7777_7777;
        index = 1'b1;
        @(negedge clk);
        @(negedge clk) abort = 1'b1;
        @(negedge clk) abort = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_offset", home_offset, 32'h0000_ABCD);
        check("abort_done", 32'(done), 32'd0);
        check("abort_error", 32'(error), 32'd0);
        check("abort_no_clear", 32'(clr_pulses), 32'(p0));
        index = 1'b0;

        // Saturation: 258 more homings for 260 total, some with stray start pulses.
        for (int i = 0; i < 258; i++) home_quick(i);
        @(negedge clk);
        check("sat_total", 32'(home_total), 32'd255);
        check("sat_model_total", 32'(m_total), 32'd255);

        // Reset asserted while in CLEAR.
        repeat (3) @(negedge clk);
        pulse_start();
        @(negedge clk);
        index = 1'b1;
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #2;
            if (cnt_clear) begin
                lat = k;
                break;
            end
        end
        check("rstclr_reached_clear", 32'(lat != 0), 32'd1);
        p0 = clr_pulses;
        reset = 1'b0;
        @(posedge clk); #2;
        check("rstclr_cnt_clear", 32'(cnt_clear), 32'd0);
        check("rstclr_busy", 32'(busy), 32'd0);
        check("rstclr_done", 32'(done), 32'd0);
        check("rstclr_offset", home_offset, 32'd0);
        check("rstclr_total", 32'(home_total), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        index = 1'b0;
        repeat (4) @(negedge clk);
        check("rstclr_no_more_clear", 32'(clr_pulses), 32'(p0));

        // Random traffic, with periods of frozen index to provoke timeouts.
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            start = ($urandom % 8) == 0;
            abort = ($urandom % 24) == 0;
            count = $urandom;
            reset = ($urandom % 400) != 0;
            if (((cyc / 250) % 4) != 3 && ($urandom % 6) == 0) index = ~index;
        end
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
